wb_arb2: RTL and testbench

Two-master to one-slave Wishbone arbiter with round-robin grant, whole-cycle bus ownership and a bus-timeout watchdog. It sits between the LM32 instruction and data ports and a single shared slave path, such as the SRAM controller or a dedicated peripheral bus. It issues an error to the waiting master when a slave never acknowledges. Grant state is exported so the logic-analyzer probe mux can observe it.

---
 rtl/wb_arb2_pkg.sv | 13 +
 rtl/wb_watchdog.sv | 30 +++
 rtl/wb_arb2.sv | 113 +++++++++++
 tb/tb_wb_arb2.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb2_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM state encoding
// and the watchdog counter width.
package wb_arb2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam int CNT_W = 16;

endpackage

// File: rtl/wb_watchdog.sv
// Bus-timeout watchdog: counts unacknowledged strobe cycles and fires for one
// cycle when the count reaches the configured limit (0 disables it).
module wb_watchdog
  import wb_arb2_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             stb,
  input  logic             ack,
  input  logic             err,
  input  logic [CNT_W-1:0] timeout,
  output logic             fire
);

  logic [CNT_W-1:0] count;

  // A real slave response in the firing cycle takes priority over the timeout.
  assign fire = (timeout != '0) && (count == timeout) && stb && !ack && !err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!stb || ack || err || fire) begin
      count <= '0;
    end else if (count != timeout) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_arb2.sv
// Two-master to one-slave Wishbone arbiter: round-robin grant, whole-cycle
// ownership, combinational request/response muxing and a timeout watchdog.
module wb_arb2
  import wb_arb2_pkg::*;
#(
  parameter int adr_width = 32,
  parameter int timeout   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [adr_width-1:0] m0_adr_i,
  input  logic [31:0]          m0_dat_i,
  input  logic [3:0]           m0_sel_i,
  input  logic                 m0_we_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  output logic [31:0]          m0_dat_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  input  logic [adr_width-1:0] m1_adr_i,
  input  logic [31:0]          m1_dat_i,
  input  logic [3:0]           m1_sel_i,
  input  logic                 m1_we_i,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  output logic [31:0]          m1_dat_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic [adr_width-1:0] s_adr_o,
  output logic [31:0]          s_dat_o,
  output logic [3:0]           s_sel_o,
  output logic                 s_we_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  input  logic [31:0]          s_dat_i,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,
  output logic [1:0]           gnt_o,
  output logic                 tmo_o
);

  state_t state, state_next;
  logic   last, last_next;
  logic   req_stb;
  logic   fire;

  // last = 1 means m1 was the most recent owner, so m0 wins the next tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  always_comb begin
    state_next = state;
    last_next  = last;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_next = last ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_next = GNT0;
        else if (m1_cyc_i)        state_next = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          last_next  = 1'b0;
          state_next = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_next  = 1'b1;
          state_next = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign s_adr_o = (state == GNT1) ? m1_adr_i : m0_adr_i;
  assign s_dat_o = (state == GNT1) ? m1_dat_i : m0_dat_i;
  assign s_sel_o = (state == GNT1) ? m1_sel_i : m0_sel_i;
  assign s_we_o  = (state == GNT1) ? m1_we_i  : m0_we_i;

  assign s_cyc_o = ((state == GNT0) && m0_cyc_i) || ((state == GNT1) && m1_cyc_i);
  assign req_stb = ((state == GNT0) && m0_cyc_i && m0_stb_i) ||
                   ((state == GNT1) && m1_cyc_i && m1_stb_i);
  assign s_stb_o = req_stb && !fire;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i && (state == GNT0);
  assign m1_ack_o = s_ack_i && (state == GNT1);
  assign m0_err_o = (s_err_i || fire) && (state == GNT0);
  assign m1_err_o = (s_err_i || fire) && (state == GNT1);

  assign gnt_o = state;
  assign tmo_o = fire;

  wb_watchdog u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .stb     (req_stb),
    .ack     (s_ack_i),
    .err     (s_err_i),
    .timeout (CNT_W'(timeout)),
    .fire    (fire)
  );

endmodule

// File: tb/tb_wb_arb2.sv
// Self-checking bench for wb_arb2: table-driven per-cycle vectors plus
// hand-written sequences for the disabled watchdog and mid-transfer reset.
module tb_wb_arb2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, s_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m1_we_i, m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i;
  logic        s_ack_i, s_err_i;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_we_o, s_cyc_o, s_stb_o, tmo_o;
  logic [1:0]  gnt_o;

  logic [31:0] nw_m0_dat_o, nw_m1_dat_o, nw_s_adr_o, nw_s_dat_o;
  logic [3:0]  nw_s_sel_o;
  logic        nw_m0_ack_o, nw_m1_ack_o, nw_m0_err_o, nw_m1_err_o;
  logic        nw_s_we_o, nw_s_cyc_o, nw_s_stb_o, nw_tmo_o;
  logic [1:0]  nw_gnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arb2 #(.adr_width(32), .timeout(8)) dut (
    .clk(clk), .reset(reset),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .gnt_o(gnt_o), .tmo_o(tmo_o)
  );

  // Second instance with the watchdog disabled, driven by the same stimulus.
  wb_arb2 #(.adr_width(32), .timeout(0)) dut_nw (
    .clk(clk), .reset(reset),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(nw_m0_dat_o), .m0_ack_o(nw_m0_ack_o),
    .m0_err_o(nw_m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(nw_m1_dat_o), .m1_ack_o(nw_m1_ack_o),
    .m1_err_o(nw_m1_err_o),
    .s_adr_o(nw_s_adr_o), .s_dat_o(nw_s_dat_o), .s_sel_o(nw_s_sel_o), .s_we_o(nw_s_we_o),
    .s_cyc_o(nw_s_cyc_o), .s_stb_o(nw_s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .gnt_o(nw_gnt_o), .tmo_o(nw_tmo_o)
  );

  // stim   = {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err}
  // exp_out = {gnt[1:0], s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err, tmo}
  typedef struct {
    logic [5:0] stim;
    logic [8:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [5:0] s, input logic [8:0] e, input int n = 1);
    for (int k = 0; k < n; k++) vecs.push_back('{stim: s, exp_out: e});
  endfunction

  function automatic logic [8:0] ctl_bits();
    return {gnt_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, tmo_o};
  endfunction

  task automatic applyStimulus(input logic [5:0] s, input logic [31:0] d);
    {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i, s_err_i} = s;
    s_dat_i = d;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [68:0] exp_req;
    int          nw_faults;
    int          tmo_count;

    reset    = 1'b1;
    m0_adr_i = 32'h1000_0A00;  m1_adr_i = 32'h2000_0B00;
    m0_dat_i = 32'hAAAA_0000;  m1_dat_i = 32'hBBBB_1111;
    m0_sel_i = 4'hF;           m1_sel_i = 4'h3;
    m0_we_i  = 1'b0;           m1_we_i  = 1'b1;
    applyStimulus(6'b00_00_00, 32'h0);

    // Contention right after reset: m0 first, handoff, then m0 again.
    add(6'b11_11_00, 9'b00_00_00_00_0);
    add(6'b11_11_00, 9'b01_11_00_00_0);
    add(6'b11_11_10, 9'b01_11_10_00_0);
    add(6'b00_11_00, 9'b01_00_00_00_0);
    add(6'b00_11_00, 9'b10_11_00_00_0);
    add(6'b00_11_10, 9'b10_11_01_00_0);
    add(6'b00_00_00, 9'b10_00_00_00_0);
    add(6'b11_11_00, 9'b00_00_00_00_0);
    add(6'b11_11_00, 9'b01_11_00_00_0);
    add(6'b11_11_10, 9'b01_11_10_00_0);
    add(6'b00_00_00, 9'b01_00_00_00_0);
    add(6'b00_00_00, 9'b00_00_00_00_0);
    // Single m1 read, slave acks two cycles after the strobe reaches it.
    add(6'b00_11_00, 9'b00_00_00_00_0);
    add(6'b00_11_00, 9'b10_11_00_00_0, 2);
    add(6'b00_11_10, 9'b10_11_01_00_0);
    add(6'b00_00_00, 9'b10_00_00_00_0);
    add(6'b00_00_00, 9'b00_00_00_00_0);
    // m1 multi-strobe cycle with m0 waiting; no preemption.
    add(6'b00_11_00, 9'b00_00_00_00_0);
    add(6'b11_11_10, 9'b10_11_01_00_0);
    add(6'b11_10_00, 9'b10_10_00_00_0);
    add(6'b11_11_10, 9'b10_11_01_00_0, 3);
    add(6'b11_00_00, 9'b10_00_00_00_0);
    add(6'b11_00_10, 9'b01_11_10_00_0);
    add(6'b00_00_00, 9'b01_00_00_00_0);
    add(6'b00_00_00, 9'b00_00_00_00_0);
    // Timeout of 8: fire after 8 unacked strobe cycles, one cycle only.
    add(6'b11_00_00, 9'b00_00_00_00_0);
    add(6'b11_00_00, 9'b01_11_00_00_0, 8);
    add(6'b11_00_00, 9'b01_10_00_10_1);
    add(6'b11_00_00, 9'b01_11_00_00_0);
    add(6'b00_00_00, 9'b01_00_00_00_0);
    add(6'b00_00_00, 9'b00_00_00_00_0);
    // Ack arriving exactly in the fire cycle wins.
    add(6'b11_00_00, 9'b00_00_00_00_0);
    add(6'b11_00_00, 9'b01_11_00_00_0, 8);
    add(6'b11_00_10, 9'b01_11_10_00_0);
    add(6'b00_00_00, 9'b01_00_00_00_0);
    add(6'b00_00_00, 9'b00_00_00_00_0);
    // Slave error routed only to the grantee.
    add(6'b00_11_00, 9'b00_00_00_00_0);
    add(6'b00_11_01, 9'b10_11_00_01_0);
    add(6'b00_00_00, 9'b10_00_00_00_0);
    add(6'b00_00_00, 9'b00_00_00_00_0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset ctl", 128'(ctl_bits()), 128'(9'b0));
    checkOutput("reset ctl nw", 128'({nw_gnt_o, nw_s_cyc_o, nw_s_stb_o, nw_tmo_o}), 128'(5'b0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[i].stim, 32'hC0DE_0000 + 32'(i));
      #1;
      checkOutput($sformatf("vec%0d ctl", i), 128'(ctl_bits()), 128'(vecs[i].exp_out));
      exp_req = (vecs[i].exp_out[8:7] == 2'b10) ? {m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i}
                                                : {m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i};
      checkOutput($sformatf("vec%0d req mux", i), 128'({s_adr_o, s_dat_o, s_sel_o, s_we_o}),
                  128'(exp_req));
      checkOutput($sformatf("vec%0d rd data", i), 128'({m0_dat_o, m1_dat_o}),
                  128'({32'hC0DE_0000 + 32'(i), 32'hC0DE_0000 + 32'(i)}));
    end

    // Hung slave for 1000 cycles: disabled watchdog never fires, enabled one
    // fires every 9th cycle (8 counting cycles plus the fire cycle).
    nw_faults = 0;
    tmo_count = 0;
    @(posedge clk);
    #1;
    applyStimulus(6'b11_00_00, 32'h0);
    repeat (1000) begin
      @(posedge clk);
      #2;
      if (nw_m0_err_o || nw_tmo_o || !nw_s_stb_o) nw_faults++;
      if (tmo_o) tmo_count++;
    end
    checkOutput("no timeout when disabled", 128'(nw_faults), 128'(0));
    checkOutput("nw grant held", 128'(nw_gnt_o), 128'(2'b01));
    checkOutput("timeout pulse count", 128'(tmo_count), 128'(111));
    applyStimulus(6'b00_00_00, 32'h0);
    repeat (2) @(posedge clk);

    // Asynchronous reset in the middle of an m1 read, then contention.
    #1;
    applyStimulus(6'b00_11_00, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(6'b00_11_10, 32'h1234_5678);
    #1;
    checkOutput("pre-reset m1 ack", 128'({gnt_o, s_cyc_o, m1_ack_o}), 128'(4'b10_1_1));
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async reset drop", 128'({gnt_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o}),
                128'(6'b0));
    #2;
    reset = 1'b0;
    applyStimulus(6'b11_11_00, 32'h0);
    @(posedge clk);
    #2;
    checkOutput("post-reset contention", 128'({gnt_o, s_cyc_o}), 128'(3'b01_1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
